// File: rtl/mnist_frame_packer_pkg.sv
// Shared constants for the MNIST frame packer.
// Holds the default geometry and the assembly FSM encoding.
package mnist_frame_packer_pkg;

  localparam int NPIX    = 784;
  localparam int NCLASS  = 10;
  localparam int FRAME_W = NPIX + NCLASS;
  localparam int PIX_OFS = NCLASS;

  localparam logic [1:0] ST_LABEL = 2'd0;
  localparam logic [1:0] ST_PIXEL = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

endpackage

// File: rtl/mnist_frame_packer_if.sv
// Beat stream in, packed frame out, both valid/ready.
// The slave side is the packer; the master side feeds and drains it.
interface mnist_frame_packer_if #(
  parameter int W = mnist_frame_packer_pkg::FRAME_W
);

  logic         s_valid;
  logic         s_ready;
  logic [7:0]   s_data;
  logic         s_last;
  logic         m_valid;
  logic         m_ready;
  logic [W-1:0] image_data;

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, image_data
  );

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, image_data
  );

endinterface

// File: rtl/mnist_frame_packer.sv
// Packs a label beat plus NPIX grayscale beats into one binarized
// frame word with a one-hot label, double-buffered toward the consumer.
module mnist_frame_packer #(
  parameter int NPIX   = mnist_frame_packer_pkg::NPIX,
  parameter int NCLASS = mnist_frame_packer_pkg::NCLASS,
  parameter int CNTW   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         pix_threshold,
  mnist_frame_packer_if.slave bus,
  output logic [CNTW-1:0]    frame_cnt,
  output logic [7:0]         drop_cnt,
  output logic               err_pulse
);

  import mnist_frame_packer_pkg::*;

  localparam int W    = NPIX + NCLASS;
  localparam int IDXW = $clog2(NPIX);
  localparam int PW   = $clog2(W);

  function automatic logic [NCLASS-1:0] onehot(
    input logic [7:0] lbl
  );
    logic [NCLASS-1:0] oh;
    for (int i = 0; i < NCLASS; i++) begin
      oh[i] = (lbl == 8'(i));
    end
    return oh;
  endfunction

  logic [1:0]      st_q, st_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [7:0]      thr_q, thr_d;
  logic            bad_q, bad_d;
  logic [W-1:0]    asm_q, asm_d;
  logic [W-1:0]    out_q, out_d;
  logic            mv_q, mv_d;
  logic [CNTW-1:0] fc_q, fc_d;
  logic [7:0]      dc_q, dc_d;
  logic            err_q;
  logic            drop;
  logic            load;
  logic            s_xfer;
  logic            m_xfer;
  logic            idx_end;
  logic [PW-1:0]   pos;

  assign bus.s_ready    = rst_n & (st_q != ST_HOLD);
  assign bus.m_valid    = mv_q;
  assign bus.image_data = out_q;
  assign frame_cnt      = fc_q;
  assign drop_cnt       = dc_q;
  assign err_pulse      = err_q;

  assign s_xfer  = bus.s_valid & bus.s_ready;
  assign m_xfer  = mv_q & bus.m_ready;
  assign idx_end = (idx_q == IDXW'(NPIX - 1));
  assign pos     = PW'(NCLASS) + PW'(idx_q);

  always_comb begin
    st_d  = st_q;
    idx_d = idx_q;
    thr_d = thr_q;
    bad_d = bad_q;
    asm_d = asm_q;
    out_d = out_q;
    drop  = 1'b0;
    load  = 1'b0;
    case (st_q)
      ST_LABEL: begin
        if (s_xfer) begin
          thr_d = pix_threshold;
          asm_d = '0;
          idx_d = '0;
          bad_d = (bus.s_data >= 8'(NCLASS));
          if (!bad_d) asm_d[NCLASS-1:0] = onehot(bus.s_data);
          st_d  = ST_PIXEL;
        end
      end
      ST_PIXEL: begin
        if (s_xfer) begin
          asm_d[pos] = (bus.s_data >= thr_q);
          idx_d      = idx_q + 1'b1;
          if (idx_end) begin
            if (!bus.s_last) begin
              drop = 1'b1;
              st_d = ST_FLUSH;
            end else if (bad_q) begin
              drop = 1'b1;
              st_d = ST_LABEL;
            end else begin
              st_d = ST_HOLD;
            end
          end else if (bus.s_last) begin
            drop = 1'b1;
            st_d = ST_LABEL;
          end
        end
      end
      ST_FLUSH: begin
        if (s_xfer && bus.s_last) st_d = ST_LABEL;
      end
      default: begin
        // Load may coincide with the consumer draining the old frame.
        if (!mv_q || bus.m_ready) begin
          load  = 1'b1;
          out_d = asm_q;
          st_d  = ST_LABEL;
        end
      end
    endcase
  end

  assign mv_d = load | (mv_q & ~m_xfer);
  assign fc_d = fc_q + CNTW'(m_xfer);
  assign dc_d = (drop && dc_q != 8'hff) ? dc_q + 8'd1 : dc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= ST_LABEL;
      idx_q <= '0;
      thr_q <= '0;
      bad_q <= 1'b0;
      asm_q <= '0;
      out_q <= '0;
      mv_q  <= 1'b0;
      fc_q  <= '0;
      dc_q  <= '0;
      err_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      idx_q <= idx_d;
      thr_q <= thr_d;
      bad_q <= bad_d;
      asm_q <= asm_d;
      out_q <= out_d;
      mv_q  <= mv_d;
      fc_q  <= fc_d;
      dc_q  <= dc_d;
      err_q <= drop;
    end
  end

endmodule
